mul_short_norm: RTL and testbench

- Post-multiply normaliser for the short (subnormal-operand) path of the pipelined FP multiplier.
- Sits downstream of the short-path operand selection and the mantissa multiplier. Consumes the raw product mantissa and the biased exponent sum.
- Does leading-zero normalisation, exponent adjustment and subnormal denormalisation. Produces a truncated mantissa plus guard/round/sticky bits for the rounding stage.
- Two-stage pipeline with valid/ready backpressure.

---
 rtl/mul_short_norm.sv | 172 +++++++++++++++++
 tb/tb_mul_short_norm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_short_norm.sv
// mul_short_norm: post-multiply normaliser for the short (subnormal-operand)
// path of the FP multiplier. It normalises the raw product, adjusts the
// exponent, and denormalises tiny results. The outputs are a truncated
// mantissa plus guard/round/sticky bits for the rounding stage. The block is
// a two-stage pipeline with valid/ready backpressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_sign, in_expo      product sign, signed biased exponent sum (EW bits)
//   in_prod               raw product (PW bits, MSB weight 2^1)
//   out_valid/out_ready   output handshake
//   out_sign, out_expo    result sign, biased exponent
//   out_mant              mantissa without the hidden bit
//   out_grs               guard, round, sticky
//   out_zero/unf/ovf      zero product, tiny result, exponent overflow
//
// Optional build macro: MUL_SHORT_NORM_FTZ_EN flushes tiny results to zero
// (sign kept, out_unf and out_zero set).

module mul_short_norm #(
  parameter int unsigned SIGN_W = 1,
  parameter int unsigned EXPO_W = 8,
  parameter int unsigned MANT_W = 23,
  localparam int unsigned PW = 2 * MANT_W + 2,
  localparam int unsigned EW = EXPO_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIGN_W-1:0] in_sign,
  input  logic [EW-1:0]     in_expo,
  input  logic [PW-1:0]     in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIGN_W-1:0] out_sign,
  output logic [EXPO_W-1:0] out_expo,
  output logic [MANT_W-1:0] out_mant,
  output logic [2:0]        out_grs,
  output logic              out_zero,
  output logic              out_unf,
  output logic              out_ovf
);

  localparam int unsigned LZ_W = $clog2(PW + 1);
  localparam int unsigned SH_W = $clog2(PW + 1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXPO_W) - 1);

  // Stage 1 registers
  logic                     s1_valid;
  logic [SIGN_W-1:0]        s1_sign;
  logic signed [EW-1:0]     s1_e1;
  logic [PW-1:0]            s1_pn;
  logic                     s1_zero;

  logic                     s2_can_take;
  logic                     s1_load;
  logic [LZ_W-1:0]          lz;

  // Stage 2 next values
  logic [EXPO_W-1:0]        n_expo;
  logic [MANT_W-1:0]        n_mant;
  logic [2:0]               n_grs;
  logic                     n_zero;
  logic                     n_unf;
  logic                     n_ovf;
  logic [EW:0]              sh_raw;
  logic [SH_W-1:0]          sh;
  logic [2*PW-1:0]          wide;
  logic [PW-1:0]            pd;
  logic                     lost;

  assign s2_can_take = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_take;
  assign s1_load     = in_valid && in_ready;

  // Leading-zero count; the highest set bit wins, all-zero gives PW.
  always_comb begin
    lz = LZ_W'(PW);
    for (int i = 0; i < int'(PW); i++) begin
      if (in_prod[i]) lz = LZ_W'(int'(PW) - 1 - i);
    end
  end

  // Stage 1: normalise and adjust the exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_e1    <= '0;
      s1_pn    <= '0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (s1_load) begin
        s1_sign <= in_sign;
        s1_e1   <= in_expo + EW'(1) - EW'(lz);
        s1_pn   <= in_prod << lz;
        s1_zero <= (in_prod == '0);
      end
    end
  end

  // Stage 2 combinational: classify and extract mantissa/GRS. The normal
  // case reuses the denormalising shifter with a shift of zero. Bits pushed
  // out of the bottom land in the lower half of 'wide' and feed sticky.
  always_comb begin
    n_expo = '0;
    n_mant = '0;
    n_grs  = '0;
    n_zero = 1'b0;
    n_unf  = 1'b0;
    n_ovf  = 1'b0;
    sh     = '0;
    sh_raw = (EW + 1)'(1) - {s1_e1[EW-1], s1_e1};
    wide   = '0;
    pd     = '0;
    lost   = 1'b0;
    if (s1_zero) begin
      n_zero = 1'b1;
    end else if (s1_e1 >= E_MAX) begin
      n_ovf  = 1'b1;
      n_expo = '1;
    end else begin
      if (s1_e1 > 0) begin
        n_expo = s1_e1[EXPO_W-1:0];
      end else begin
        n_unf = 1'b1;
        sh    = (sh_raw >= (EW + 1)'(PW)) ? SH_W'(PW) : SH_W'(sh_raw);
      end
      wide   = {s1_pn, {PW{1'b0}}} >> sh;
      pd     = wide[2*PW-1:PW];
      lost   = |wide[PW-1:0];
      n_mant = pd[PW-2 -: MANT_W];
      n_grs  = {pd[PW-MANT_W-2], pd[PW-MANT_W-3], (|pd[PW-MANT_W-4:0]) | lost};
`ifdef MUL_SHORT_NORM_FTZ_EN
      if (n_unf) begin
        n_mant = '0;
        n_grs  = '0;
        n_zero = 1'b1;
      end
`endif
    end
  end

  // Stage 2 registers: output payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= '0;
      out_expo  <= '0;
      out_mant  <= '0;
      out_grs   <= '0;
      out_zero  <= 1'b0;
      out_unf   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (s2_can_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= s1_sign;
        out_expo <= n_expo;
        out_mant <= n_mant;
        out_grs  <= n_grs;
        out_zero <= n_zero;
        out_unf  <= n_unf;
        out_ovf  <= n_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mul_short_norm.sv
// tb_mul_short_norm: randomized and directed self-checking bench for
// mul_short_norm, scored against an arithmetic reference model.
module tb_mul_short_norm;

  localparam int unsigned PW = 48;
  localparam int unsigned EW = 10;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_sign;
  logic [9:0]  in_expo;
  logic [47:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_sign;
  logic [7:0]  out_expo;
  logic [22:0] out_mant;
  logic [2:0]  out_grs;
  logic        out_zero;
  logic        out_unf;
  logic        out_ovf;

  mul_short_norm dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_expo(in_expo), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_expo(out_expo), .out_mant(out_mant),
    .out_grs(out_grs), .out_zero(out_zero), .out_unf(out_unf), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [37:0] exp_q[$];
  logic        hold = 1'b0;
  logic [37:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic logic [37:0] pack_out();
    return {out_sign, out_expo, out_mant, out_grs, out_zero, out_unf, out_ovf};
  endfunction

  // Reference: locate the leading one, scale the value so the mantissa LSB
  // sits at bit t of the normalised product, and slice by plain arithmetic.
  function automatic logic [37:0] ref_model(input logic s, input logic [9:0] ex, input logic [47:0] prod);
    int p, lz, e1, sh, t;
    longint unsigned pn, kept;
    logic g, r, st, z, u;
    logic [7:0]  eo;
    logic [22:0] m;
    if (prod == 48'd0) return {s, 8'd0, 23'd0, 3'b000, 1'b1, 1'b0, 1'b0};
    p = 47;
    while (prod[p] == 1'b0) p--;
    lz = 47 - p;
    e1 = int'($signed(ex)) + 1 - lz;
    e1 = int'($signed(10'(e1)));
    if (e1 >= 255) return {s, 8'hFF, 23'd0, 3'b000, 1'b0, 1'b0, 1'b1};
    pn = longint'(prod) << lz;
    sh = (e1 >= 1) ? 0 : ((1 - e1 > 48) ? 48 : 1 - e1);
    t  = 24 + sh;
    kept = (t >= 48) ? 64'd0 : (pn >> t);
    m  = kept[22:0];
    g  = (t - 1 >= 48) ? 1'b0 : 1'(pn >> (t - 1));
    r  = (t - 2 >= 48) ? 1'b0 : 1'(pn >> (t - 2));
    st = (t - 2 >= 48) ? (pn != 0) : ((pn & ((64'd1 << (t - 2)) - 1)) != 0);
    z  = 1'b0;
    if (e1 >= 1) begin
      eo = e1[7:0];
      u  = 1'b0;
    end else begin
      eo = 8'd0;
      u  = 1'b1;
`ifdef MUL_SHORT_NORM_FTZ_EN
      m = 23'd0; g = 1'b0; r = 1'b0; st = 1'b0; z = 1'b1;
`endif
    end
    return {s, eo, m, g, r, st, z, u, 1'b0};
  endfunction

  // Scoreboard/monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
      if (hold) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_payload", 64'(pack_out()), 64'(held));
      end
      if (out_valid && !out_ready) begin
        hold = 1'b1;
        held = pack_out();
      end else begin
        hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
        else chk("result", 64'(pack_out()), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_sign[0], in_expo, in_prod));
    end
  end

  task automatic new_beat();
    logic [63:0] w;
    w = {$urandom, $urandom};
    in_sign = 1'($urandom);
    in_prod = ($urandom % 8 == 0) ? 48'd0 : (w[47:0] >> $urandom_range(0, 47));
    in_expo = 10'($urandom_range(0, 600) - 200);
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic v, input logic r, output logic acc);
    in_valid  = v;
    out_ready = r;
    #1;
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 20) begin
      step(1'b0, 1'b1, acc);
      c++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_one(input string tag, input logic [9:0] ex, input logic [47:0] p, input logic [37:0] want);
    int cyc;
    in_sign   = 1'b0;
    in_expo   = ex;
    in_prod   = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd2);
    chk({tag, "_value"}, 64'(pack_out()), 64'(want));
    drain();
  endtask

  initial begin
    logic acc;
    int sent, c;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = '0; in_expo = '0; in_prod = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_payload", 64'(pack_out()), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed corner cases
    run_one("one_x_one", 10'd127, 48'd1 << 46, {1'b0, 8'd127, 23'd0, 3'b000, 3'b000});
`ifdef MUL_SHORT_NORM_FTZ_EN
    run_one("min_sub", 10'd1, 48'd1 << 23, {1'b0, 8'd0, 23'd0, 3'b000, 3'b110});
    run_one("e1_zero", 10'd0, 48'd1 << 46, {1'b0, 8'd0, 23'd0, 3'b000, 3'b110});
`else
    run_one("min_sub", 10'd1, 48'd1 << 23, {1'b0, 8'd0, 23'd1, 3'b000, 3'b010});
    run_one("e1_zero", 10'd0, 48'd1 << 46, {1'b0, 8'd0, 23'h400000, 3'b000, 3'b010});
`endif
    run_one("zero", 10'd50, 48'd0, {1'b0, 8'd0, 23'd0, 3'b000, 3'b100});
    run_one("ovf", 10'd254, 48'd1 << 47, {1'b0, 8'hFF, 23'd0, 3'b000, 3'b001});
    run_one("max_norm", 10'd254, 48'd1 << 46, {1'b0, 8'hFE, 23'd0, 3'b000, 3'b000});
    run_one("e1_one", 10'd1, 48'd1 << 46, {1'b0, 8'd1, 23'd0, 3'b000, 3'b000});
    run_one("grs", 10'd127, (48'd1 << 46) | (48'd1 << 22) | (48'd1 << 21) | 48'd1,
            {1'b0, 8'd127, 23'd0, 3'b111, 3'b000});

    // Eight back-to-back beats with out_ready pattern 1,0,0,1
    sent = 0; c = 0;
    new_beat();
    while (sent < 8 && c < 100) begin
      step(1'b1, (c % 4 == 0) || (c % 4 == 3), acc);
      if (acc) begin sent++; new_beat(); end
      c++;
    end
    chk("burst_sent", 64'(sent), 64'd8);
    in_valid = 1'b0;
    drain();

    // Randomized traffic with random backpressure
    new_beat();
    for (int i = 0; i < 3000; i++) begin
      step($urandom % 4 != 0, $urandom % 3 != 0, acc);
      if (acc || !in_valid) new_beat();
    end
    in_valid = 1'b0;
    drain();

    // Reset with both stages full
    sent = 0; c = 0;
    new_beat();
    while (sent < 2 && c < 20) begin
      step(1'b1, 1'b0, acc);
      if (acc) begin sent++; new_beat(); end
      c++;
    end
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_payload", 64'(pack_out()), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_one("post_rst", 10'd127, 48'd1 << 46, {1'b0, 8'd127, 23'd0, 3'b000, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
